obi_spi_mailbox: RTL and testbench

// - OBI slave sitting directly downstream of the SPI slave's OBI master port; the SPI host writes
//   32-bit messages into it over OBI, and the on-chip CPU drains them through a stream port.
// - Provides a message FIFO, a status/control register set, a sticky overflow flag and a level IRQ.

---
 rtl/obi_spi_mbox_pkg.sv | 19 +
 rtl/obi_spi_mbox_fifo.sv | 56 +++++
 rtl/obi_spi_mailbox.sv | 139 +++++++++++++
 tb/tb_obi_spi_mailbox.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/obi_spi_mbox_pkg.sv
// Shared definitions for the OBI-to-CPU SPI message mailbox: register indices and bit positions.
package obi_spi_mbox_pkg;

  // Register index taken from byte address bits [3:2] (DATA 0x0, STATUS 0x4, CTRL 0x8, SCRATCH 0xC).
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CTRL    = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_idx_e;

  localparam int unsigned STATUS_FULL_BIT  = 31;
  localparam int unsigned STATUS_EMPTY_BIT = 30;
  localparam int unsigned STATUS_OVF_BIT   = 29;

  localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
  localparam int unsigned CTRL_OVF_CLR_BIT = 1;

endpackage

// File: rtl/obi_spi_mbox_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is taken only alongside a pop.
module obi_spi_mbox_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign count     = wptr_q - rptr_q;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem_q[rptr_q[AW-1:0]];

  // In the full+pop case the write slot equals the head slot, which is read before the edge.
  always_comb begin
    mem_d   = mem_q;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop_ok);
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/obi_spi_mailbox.sv
// OBI slave mailbox: SPI host pushes words over OBI, CPU drains them via a stream port.
// Optional 0xC scratch register enabled by `define OBI_SPI_MBOX_SCRATCH_EN.
module obi_spi_mailbox
  import obi_spi_mbox_pkg::*;
#(
  parameter int unsigned OBI_ADDR_WIDTH = 32,
  parameter int unsigned OBI_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                      obi_aclk,
  input  logic                      obi_aresetn,
  input  logic                      obi_slave_req,
  output logic                      obi_slave_gnt,
  input  logic [OBI_ADDR_WIDTH-1:0] obi_slave_addr,
  input  logic                      obi_slave_we,
  input  logic [OBI_DATA_WIDTH-1:0] obi_slave_w_data,
  input  logic [3:0]                obi_slave_be,
  output logic                      obi_slave_r_valid,
  output logic [OBI_DATA_WIDTH-1:0] obi_slave_r_data,
  output logic [31:0]               mbox_data,
  output logic                      mbox_valid,
  input  logic                      mbox_ready,
  output logic                      mbox_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                      r_valid_q, r_valid_d;
  logic [OBI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                      irq_en_q, irq_en_d;
  logic                      ovf_q, ovf_d;
  logic                      irq_q, irq_d;
  logic [31:0]               scratch_rd;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          req_fire, wr_fire, push_req, pop_fire;
  logic [31:0]   status, rdata;
  reg_idx_e      reg_idx;
  logic          unused_c;

  assign unused_c = ^{obi_slave_addr[OBI_ADDR_WIDTH-1:4], obi_slave_addr[1:0], obi_slave_be[3:1]};

  // Requests never stall; grant is withheld only while in reset.
  assign obi_slave_gnt     = obi_slave_req & obi_aresetn;
  assign obi_slave_r_valid = r_valid_q;
  assign obi_slave_r_data  = r_data_q;
  assign mbox_valid        = ~fifo_empty;
  assign mbox_irq          = irq_q;

  always_comb begin
    req_fire = obi_slave_req & obi_aresetn;
    wr_fire  = req_fire & obi_slave_we;
    reg_idx  = reg_idx_e'(obi_slave_addr[3:2]);
    push_req = wr_fire & (reg_idx == REG_DATA);
    pop_fire = mbox_ready & ~fifo_empty;

    status                   = '0;
    status[CW-1:0]           = fifo_count;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_OVF_BIT]   = ovf_q;

    unique case (reg_idx)
      REG_STATUS:  rdata = status;
      REG_CTRL:    rdata = 32'(irq_en_q);
      REG_SCRATCH: rdata = scratch_rd;
      default:     rdata = '0;
    endcase

    r_valid_d = req_fire;
    r_data_d  = (req_fire & ~obi_slave_we) ? OBI_DATA_WIDTH'(rdata) : '0;

    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_fire && reg_idx == REG_CTRL && obi_slave_be[0]) begin
      irq_en_d = obi_slave_w_data[CTRL_IRQ_EN_BIT];
      if (obi_slave_w_data[CTRL_OVF_CLR_BIT]) ovf_d = 1'b0;
    end
    // A dropped push sets overflow and wins over a clear in the same cycle.
    if (push_req && fifo_full && !pop_fire) ovf_d = 1'b1;

    irq_d = irq_en_q & ~fifo_empty;
  end

  always_ff @(posedge obi_aclk) begin
    if (!obi_aresetn) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

`ifdef OBI_SPI_MBOX_SCRATCH_EN
  logic [31:0] scratch_q, scratch_d;

  assign scratch_rd = scratch_q;

  always_comb begin
    scratch_d = scratch_q;
    if (wr_fire && reg_idx == REG_SCRATCH) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (obi_slave_be[b]) scratch_d[8*b +: 8] = obi_slave_w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge obi_aclk) begin
    if (!obi_aresetn) scratch_q <= '0;
    else              scratch_q <= scratch_d;
  end
`else
  assign scratch_rd = '0;
`endif

  obi_spi_mbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (obi_aclk),
    .rst_n     (obi_aresetn),
    .push      (push_req),
    .push_data (32'(obi_slave_w_data)),
    .pop       (mbox_ready),
    .head_data (mbox_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_obi_spi_mailbox.sv
// Self-checking bench for obi_spi_mailbox: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_obi_spi_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_i, we_i, rdy_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, mvalid_o, irq_o;
  logic [31:0] rdata_o, mdata_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_irq_en, m_irq, m_rv;
  logic [31:0] m_scr, m_rd;

  always #5 clk = ~clk;

  obi_spi_mailbox dut (
    .obi_aclk          (clk),
    .obi_aresetn       (rstn),
    .obi_slave_req     (req_i),
    .obi_slave_gnt     (gnt_o),
    .obi_slave_addr    (addr_i),
    .obi_slave_we      (we_i),
    .obi_slave_w_data  (wdata_i),
    .obi_slave_be      (be_i),
    .obi_slave_r_valid (rvalid_o),
    .obi_slave_r_data  (rdata_o),
    .mbox_data         (mdata_o),
    .mbox_valid        (mvalid_o),
    .mbox_ready        (rdy_i),
    .mbox_irq          (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, predict with the model, compare outputs just after the edge.
  task automatic step(input bit req, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input bit rdy);
    int          sz;
    logic [31:0] rd;
    bit          pop;
    bit          ovf_set;
    bit          irq_nx;
    @(negedge clk);
    req_i = req; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be; rdy_i = rdy;
    #1;
    check("gnt", 32'(gnt_o), 32'(req));
    sz = mq.size();
    case (addr[3:2])
      2'd1: rd = (sz == DEPTH ? 32'h8000_0000 : 32'h0) | (sz == 0 ? 32'h4000_0000 : 32'h0)
               | (m_ovf ? 32'h2000_0000 : 32'h0) | 32'(sz);
      2'd2: rd = {31'd0, m_irq_en};
`ifdef OBI_SPI_MBOX_SCRATCH_EN
      2'd3: rd = m_scr;
`else
      2'd3: rd = 32'h0;
`endif
      default: rd = 32'h0;
    endcase
    m_rv    = req;
    m_rd    = (req && !we) ? rd : 32'h0;
    irq_nx  = m_irq_en && (sz > 0);
    pop     = rdy && (sz > 0);
    ovf_set = 1'b0;
    if (pop) void'(mq.pop_front());
    if (req && we) begin
      case (addr[3:2])
        2'd0: if (sz < DEPTH || pop) mq.push_back(wdata); else ovf_set = 1'b1;
        2'd2: if (be[0]) begin
          m_irq_en = wdata[0];
          if (wdata[1]) m_ovf = 1'b0;
        end
        2'd3: for (int b = 0; b < 4; b++) if (be[b]) m_scr[8*b +: 8] = wdata[8*b +: 8];
        default: ;
      endcase
    end
    if (ovf_set) m_ovf = 1'b1;
    m_irq = irq_nx;
    @(posedge clk);
    #1;
    check("r_valid", 32'(rvalid_o), 32'(m_rv));
    if (m_rv) check("r_data", rdata_o, m_rd);
    check("mbox_valid", 32'(mvalid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) check("mbox_data", mdata_o, mq[0]);
    check("mbox_irq", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic do_reset(input bit req_during);
    @(negedge clk);
    rstn = 1'b0; req_i = req_during; we_i = 1'b0; addr_i = 32'h4; rdy_i = 1'b0;
    #1;
    check("gnt_in_reset", 32'(gnt_o), 32'h0);
    @(posedge clk);
    #1;
    check("rst_r_valid", 32'(rvalid_o), 32'h0);
    check("rst_r_data", rdata_o, 32'h0);
    check("rst_mbox_valid", 32'(mvalid_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    @(negedge clk);
    rstn = 1'b1; req_i = 1'b0;
    mq.delete();
    m_ovf = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0; m_scr = 32'h0;
  endtask

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          rdy;
    logic [31:0] exp_rd;
    bit          exp_mv;
    logic [31:0] exp_md;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [31:0] head;
    logic [31:0] exp_scr;
    rstn = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0; rdy_i = 1'b0;
    m_scr = 32'h0;

    tv[0] = '{1'b1, 1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h4000_0000, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 32'h0,         32'h1111_1111, 4'hF, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    tv[2] = '{1'b1, 1'b1, 32'h0,         32'h2222_2222, 4'h0, 1'b0, 32'h0,         1'b1, 32'h1111_1111};
    tv[3] = '{1'b1, 1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h0000_0002, 1'b1, 32'h1111_1111};
    tv[4] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h0,         1'b1, 32'h2222_2222};
    tv[5] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 32'h0};
    tv[6] = '{1'b1, 1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h4000_0000, 1'b0, 32'h0};
    tv[7] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0, 32'h0};
    tv[8] = '{1'b1, 1'b0, 32'h0,         32'h0,         4'hF, 1'b0, 32'h0,         1'b0, 32'h0};

    do_reset(1'b0);

    foreach (tv[i]) begin
      step(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].be, tv[i].rdy);
      check($sformatf("vec%0d_r_valid", i), 32'(rvalid_o), 32'(tv[i].req));
      if (tv[i].req) check($sformatf("vec%0d_r_data", i), rdata_o, tv[i].exp_rd);
      check($sformatf("vec%0d_mbox_valid", i), 32'(mvalid_o), 32'(tv[i].exp_mv));
      if (tv[i].exp_mv) check($sformatf("vec%0d_mbox_data", i), mdata_o, tv[i].exp_md);
    end

    // Fill, overflow, clear, then full push with simultaneous pop.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 32'h0, 32'h1000_0000 + 32'(i), 4'hF, 0);
    step(1, 1, 32'h0, 32'hDEAD_BEEF, 4'hF, 0);
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    check("status_overflow", rdata_o, 32'hA000_0008);
    step(1, 1, 32'h8, 32'h2, 4'h1, 0);
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    check("status_ovf_cleared", rdata_o, 32'h8000_0008);
    step(1, 1, 32'h0, 32'hCAFE_0009, 4'hF, 1);
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    check("status_full_pushpop", rdata_o, 32'h8000_0008);
    for (int i = 0; i < DEPTH; i++) begin
      head = mdata_o;
      if (i == DEPTH - 1) check("drain_last_cafe", head, 32'hCAFE_0009);
      else check($sformatf("drain%0d", i), head, 32'h1000_0001 + 32'(i));
      step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    end
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    check("status_drained", rdata_o, 32'h4000_0000);

    // IRQ timing around a push into an empty FIFO and the pop that empties it.
    step(1, 1, 32'h8, 32'h1, 4'h1, 0);
    step(1, 1, 32'h0, 32'h0000_0055, 4'hF, 0);
    check("irq_push_cycle", 32'(irq_o), 32'h0);
    step(0, 0, 32'h0, 32'h0, 4'h0, 0);
    check("irq_asserted", 32'(irq_o), 32'h1);
    step(0, 0, 32'h0, 32'h0, 4'h0, 1);
    check("irq_pop_cycle", 32'(irq_o), 32'h1);
    step(0, 0, 32'h0, 32'h0, 4'h0, 0);
    check("irq_deasserted", 32'(irq_o), 32'h0);

    // Scratch with partial byte enables.
    step(1, 1, 32'hC, 32'hA5A5_A5A5, 4'b0011, 0);
    step(1, 0, 32'hC, 32'h0, 4'hF, 0);
`ifdef OBI_SPI_MBOX_SCRATCH_EN
    exp_scr = 32'h0000_A5A5;
`else
    exp_scr = 32'h0;
`endif
    check("scratch_read", rdata_o, exp_scr);

    // Reset with a response pending and data in the FIFO.
    step(1, 1, 32'h0, 32'h0000_0077, 4'hF, 0);
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    do_reset(1'b1);
    step(1, 0, 32'h4, 32'h0, 4'hF, 0);
    check("status_after_reset", rdata_o, 32'h4000_0000);

    // Randomized traffic, weighted toward DATA writes so full/overflow paths are exercised.
    for (int n = 0; n < 800; n++) begin
      bit          r_req, r_we, r_rdy;
      logic [31:0] r_addr;
      logic [1:0]  idx;
      r_req = ($urandom_range(0, 9) < 7);
      r_we  = ($urandom_range(0, 3) != 0);
      idx   = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
      r_addr = {$urandom} & 32'hFFFF_FFF3;
      r_addr[3:2] = idx;
      r_rdy = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 7));
      step(r_req, r_we, r_addr, $urandom, 4'($urandom), r_rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
